// File: rtl/fifo_rd_packer_pkg.sv
// Shared constants and types for the FIFO read-side packer.
package fifo_rd_packer_pkg;

  localparam int unsigned FIFO_DW = 8;

  // Width needed to count 0..n bytes inclusive
  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_FLUSH_WAIT = 2'd1,
    ST_FLUSH_EMIT = 2'd2
  } flush_state_e;

endpackage

// File: rtl/fifo_rd_packer_byte_lane_assembler.sv
// Byte lane register file: writes each captured byte into the next free lane, cleared on word transfer.
module fifo_rd_packer_byte_lane_assembler
  import fifo_rd_packer_pkg::*;
#(
  parameter  int unsigned BYTES = 4,
  localparam int unsigned BW    = cnt_width(BYTES)
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     wr_en_i,
  input  logic [FIFO_DW-1:0]       wr_data_i,
  input  logic                     clear_i,
  output logic [FIFO_DW*BYTES-1:0] lanes_o,
  output logic [BW-1:0]            cnt_o
);

  logic [BYTES-1:0][FIFO_DW-1:0] lanes_q, lanes_d;
  logic [BW-1:0]                 cnt_q, cnt_d;

  // Clear and write never coincide: the credit check keeps a read in flight from meeting a transfer
  always_comb begin
    lanes_d = lanes_q;
    cnt_d   = cnt_q;
    if (clear_i) begin
      lanes_d = '0;
      cnt_d   = '0;
    end else if (wr_en_i) begin
      for (int unsigned i = 0; i < BYTES; i++) begin
        if (cnt_q == BW'(i)) lanes_d[i] = wr_data_i;
      end
      cnt_d = cnt_q + BW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lanes_q <= '0;
      cnt_q   <= '0;
    end else begin
      lanes_q <= lanes_d;
      cnt_q   <= cnt_d;
    end
  end

  assign lanes_o = lanes_q;
  assign cnt_o   = cnt_q;

endmodule

// File: rtl/fifo_rd_packer.sv
// Drains bytes from an 8-bit FIFO read port and packs them little-endian into words on a valid/ready stream.
module fifo_rd_packer
  import fifo_rd_packer_pkg::*;
#(
  parameter  int unsigned BYTES = 4,
  parameter  int unsigned CNT_W = 16,
  localparam int unsigned BW    = cnt_width(BYTES),
  localparam int unsigned WW    = FIFO_DW * BYTES
) (
  input  logic               clk_r,
  input  logic               rst_n,
  output logic               en_r,
  input  logic [FIFO_DW-1:0] data_r,
  input  logic               empty,
  input  logic               flush,
  output logic [WW-1:0]      word_data,
  output logic [BW-1:0]      word_bytes,
  output logic               word_valid,
  input  logic               word_ready,
  output logic               flush_busy,
  output logic [CNT_W-1:0]   rd_cnt
);

  flush_state_e      state_q, state_d;
  logic              flush_busy_q, flush_busy_d;
  logic              rd_pend_q;
  logic [CNT_W-1:0]  rd_cnt_q;
  logic              word_valid_q, word_valid_d;
  logic [WW-1:0]     word_data_q, word_data_d;
  logic [BW-1:0]     word_bytes_q, word_bytes_d;
  logic [WW-1:0]     asm_lanes;
  logic [BW-1:0]     asm_cnt;
  logic              en_r_c, slot_free_c, drain_c, xfer_c;

  // Credit: bytes held plus the one in flight must leave room in the assembly
  assign en_r_c = !empty && !flush_busy_q &&
                  (((BW+1)'(asm_cnt) + (BW+1)'(rd_pend_q)) < (BW+1)'(BYTES));

  assign slot_free_c = !word_valid_q || word_ready;
  assign drain_c     = flush_busy_q && !rd_pend_q && (asm_cnt != '0);
  assign xfer_c      = ((asm_cnt == BW'(BYTES)) || drain_c) && slot_free_c;

  fifo_rd_packer_byte_lane_assembler #(.BYTES(BYTES)) u_asm (
    .clk_i     (clk_r),
    .rst_ni    (rst_n),
    .wr_en_i   (rd_pend_q),
    .wr_data_i (data_r),
    .clear_i   (xfer_c),
    .lanes_o   (asm_lanes),
    .cnt_o     (asm_cnt)
  );

  always_ff @(posedge clk_r or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // EMIT holds a pending partial word while the output slot is still occupied
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:       if (flush) state_d = ST_FLUSH_WAIT;
      ST_FLUSH_WAIT: begin
        if (!rd_pend_q) begin
          if (asm_cnt == '0 || slot_free_c) state_d = ST_IDLE;
          else                              state_d = ST_FLUSH_EMIT;
        end
      end
      ST_FLUSH_EMIT: if (slot_free_c) state_d = ST_IDLE;
      default:       state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    flush_busy_d = (state_d != ST_IDLE);
    word_valid_d = word_valid_q && !word_ready;
    word_data_d  = word_data_q;
    word_bytes_d = word_bytes_q;
    if (xfer_c) begin
      word_valid_d = 1'b1;
      word_data_d  = asm_lanes;
      word_bytes_d = asm_cnt;
    end
  end

  always_ff @(posedge clk_r or negedge rst_n) begin
    if (!rst_n) begin
      flush_busy_q <= 1'b0;
      rd_pend_q    <= 1'b0;
      rd_cnt_q     <= '0;
      word_valid_q <= 1'b0;
      word_data_q  <= '0;
      word_bytes_q <= '0;
    end else begin
      flush_busy_q <= flush_busy_d;
      rd_pend_q    <= en_r_c;
      if (en_r_c) rd_cnt_q <= rd_cnt_q + CNT_W'(1);
      word_valid_q <= word_valid_d;
      word_data_q  <= word_data_d;
      word_bytes_q <= word_bytes_d;
    end
  end

  assign en_r       = en_r_c;
  assign word_data  = word_data_q;
  assign word_bytes = word_bytes_q;
  assign word_valid = word_valid_q;
  assign flush_busy = flush_busy_q;
  assign rd_cnt     = rd_cnt_q;

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Scoreboard bench for fifo_rd_packer (BYTES=4, CNT_W=4) with a behavioural FIFO read port.
module tb_fifo_rd_packer;

  logic        clk_r = 1'b0;
  logic        rst_n = 1'b0;
  logic        en_r;
  logic [7:0]  data_r;
  logic        empty;
  logic        flush = 1'b0;
  logic [31:0] word_data;
  logic [2:0]  word_bytes;
  logic        word_valid;
  logic        word_ready = 1'b0;
  logic        flush_busy;
  logic [3:0]  rd_cnt;

  typedef struct packed {
    logic [31:0] data;
    logic [2:0]  nbytes;
  } exp_t;

  exp_t expq[$];
  int   checks = 0;
  int   errors = 0;

  logic [7:0] mem [0:255];
  logic [7:0] wr_idx = 8'd0;
  logic [7:0] rd_idx;
  logic       gate_empty = 1'b0;
  logic       toggle_en  = 1'b0;

  always #5 clk_r = ~clk_r;

  fifo_rd_packer #(.BYTES(4), .CNT_W(4)) dut (
    .clk_r      (clk_r),
    .rst_n      (rst_n),
    .en_r       (en_r),
    .data_r     (data_r),
    .empty      (empty),
    .flush      (flush),
    .word_data  (word_data),
    .word_bytes (word_bytes),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .flush_busy (flush_busy),
    .rd_cnt     (rd_cnt)
  );

  // FIFO read port model: data one cycle after en_r, contents dropped on reset
  assign empty = (rd_idx == wr_idx) || gate_empty;

  always @(posedge clk_r or negedge rst_n) begin
    if (!rst_n) begin
      rd_idx <= wr_idx;
      data_r <= 8'h00;
    end else if (en_r) begin
      data_r <= mem[rd_idx];
      rd_idx <= rd_idx + 8'd1;
    end
  end

  always @(negedge clk_r) begin
    if (toggle_en) gate_empty = ~gate_empty;
    else           gate_empty = 1'b0;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void push_exp(input logic [31:0] d, input logic [2:0] n);
    exp_t e;
    e.data   = d;
    e.nbytes = n;
    expq.push_back(e);
  endfunction

  task automatic push_bytes(input logic [7:0] first, input int n);
    logic [7:0] b;
    b = first;
    for (int i = 0; i < n; i++) begin
      mem[wr_idx] = b;
      wr_idx      = wr_idx + 8'd1;
      b           = b + 8'd1;
    end
  endtask

  // Monitor: pops an expected word on every accepted transfer
  always begin
    exp_t e;
    @(negedge clk_r);
    #1;
    if (en_r) check("en_r_while_empty", 64'(empty), 64'd0);
    if (word_valid && word_ready) begin
      if (expq.size() == 0) begin
        check("unexpected_word", 64'(word_data), 64'hDEAD_DEAD_DEAD);
      end else begin
        e = expq.pop_front();
        check("word_data", 64'(word_data), 64'(e.data));
        check("word_bytes", 64'(word_bytes), 64'(e.nbytes));
      end
    end
  end

  task automatic wait_valid(input int n);
    int i;
    i = 0;
    while (!word_valid && i < n) begin
      @(negedge clk_r);
      #1;
      i++;
    end
    check("wait_valid", 64'(word_valid), 64'd1);
  endtask

  task automatic wait_idle(input int n);
    int  i;
    logic done;
    i    = 0;
    done = 1'b0;
    while (!done && i < n) begin
      @(negedge clk_r);
      #1;
      done = (rd_idx == wr_idx) && (expq.size() == 0) && !word_valid;
      i++;
    end
    check("wait_idle", 64'(done), 64'd1);
    repeat (2) @(negedge clk_r);
  endtask

  task automatic do_reset();
    @(negedge clk_r);
    rst_n = 1'b0;
    expq.delete();
    repeat (2) @(negedge clk_r);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t, required end before 200000", $time);
    $fatal(1);
  end

  initial begin
    // Power-on reset values
    repeat (2) @(negedge clk_r);
    #1;
    check("rst_en_r", 64'(en_r), 64'd0);
    check("rst_word_valid", 64'(word_valid), 64'd0);
    check("rst_word_data", 64'(word_data), 64'd0);
    check("rst_word_bytes", 64'(word_bytes), 64'd0);
    check("rst_flush_busy", 64'(flush_busy), 64'd0);
    check("rst_rd_cnt", 64'(rd_cnt), 64'd0);

    // Reset mid-stream with a word held under backpressure
    @(negedge clk_r);
    rst_n = 1'b1;
    word_ready = 1'b0;
    push_bytes(8'hE0, 6);
    wait_valid(40);
    repeat (3) @(negedge clk_r);
    rst_n = 1'b0;
    #1;
    check("midrst_en_r", 64'(en_r), 64'd0);
    check("midrst_word_valid", 64'(word_valid), 64'd0);
    check("midrst_word_data", 64'(word_data), 64'd0);
    check("midrst_word_bytes", 64'(word_bytes), 64'd0);
    check("midrst_flush_busy", 64'(flush_busy), 64'd0);
    check("midrst_rd_cnt", 64'(rd_cnt), 64'd0);
    repeat (2) @(negedge clk_r);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_r);
      #1;
      check("postrst_en_r_idle", 64'(en_r), 64'd0);
    end

    // Plain stream of two full words
    @(negedge clk_r);
    word_ready = 1'b1;
    push_exp(32'h0403_0201, 3'd4);
    push_exp(32'h0807_0605, 3'd4);
    push_bytes(8'h01, 8);
    #1;
    check("stream_en_r_starts", 64'(en_r), 64'd1);
    wait_idle(100);
    check("stream_rd_cnt", 64'(rd_cnt), 64'd8);

    // Backpressure: 12 bytes, consumer stalled for 20 cycles
    do_reset();
    @(negedge clk_r);
    word_ready = 1'b0;
    push_exp(32'h1312_1110, 3'd4);
    push_exp(32'h1716_1514, 3'd4);
    push_exp(32'h1B1A_1918, 3'd4);
    push_bytes(8'h10, 12);
    repeat (20) @(negedge clk_r);
    #1;
    check("bp_rd_cnt", 64'(rd_cnt), 64'd8);
    check("bp_en_r_stalled", 64'(en_r), 64'd0);
    check("bp_word_valid", 64'(word_valid), 64'd1);
    @(negedge clk_r);
    word_ready = 1'b1;
    wait_idle(100);

    // Flush of a three-byte partial word
    @(negedge clk_r);
    push_exp(32'h00A3_A2A1, 3'd3);
    push_bytes(8'hA1, 3);
    repeat (6) @(negedge clk_r);
    flush = 1'b1;
    @(negedge clk_r);
    flush = 1'b0;
    #1;
    check("flush3_busy_set", 64'(flush_busy), 64'd1);
    wait_valid(20);
    check("flush3_busy_clear", 64'(flush_busy), 64'd0);
    wait_idle(50);

    // Flush with nothing assembled: busy for exactly one cycle, no word
    @(negedge clk_r);
    flush = 1'b1;
    @(negedge clk_r);
    flush = 1'b0;
    #1;
    check("flush0_busy_1st", 64'(flush_busy), 64'd1);
    check("flush0_no_valid_1st", 64'(word_valid), 64'd0);
    @(negedge clk_r);
    #1;
    check("flush0_busy_2nd", 64'(flush_busy), 64'd0);
    check("flush0_no_valid_2nd", 64'(word_valid), 64'd0);

    // Flush in the same cycle as a read: the byte lands in the flushed word
    @(negedge clk_r);
    push_exp(32'h0000_00C5, 3'd1);
    push_bytes(8'hC5, 1);
    flush = 1'b1;
    #1;
    check("flush_coinc_en_r", 64'(en_r), 64'd1);
    @(negedge clk_r);
    flush = 1'b0;
    wait_idle(50);

    // Toggling empty and counter wrap with 20 bytes
    do_reset();
    @(negedge clk_r);
    word_ready = 1'b1;
    toggle_en  = 1'b1;
    push_exp(32'h3332_3130, 3'd4);
    push_exp(32'h3736_3534, 3'd4);
    push_exp(32'h3B3A_3938, 3'd4);
    push_exp(32'h3F3E_3D3C, 3'd4);
    push_exp(32'h4342_4140, 3'd4);
    push_bytes(8'h30, 20);
    wait_idle(300);
    check("wrap_rd_cnt", 64'(rd_cnt), 64'd4);
    toggle_en = 1'b0;

    repeat (3) @(negedge clk_r);
    check("scoreboard_drained", 64'(expq.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
